// File: rtl/dequant_ht_unpack_pkg.sv
// Shared quantization constants, FSM encoding and lane helpers
// for the Ht/Ct/Xt dequantizers.
package dequant_ht_unpack_pkg;

  localparam logic [7:0] ZERO_DATA_DEF = 8'd128;
  localparam logic [9:0] SCALE_W_DEF   = 10'd128;

  localparam int         LANES      = 4;
  localparam int         LANE_BITS  = 8;
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // lane0 sits in the low byte
  function automatic logic [7:0] lane_byte(
    input logic [31:0] w,
    input logic [1:0]  l
  );
    logic [7:0] b;
    b = 8'd0;
    unique case (l)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dequant_lane.sv
// Combinational byte dequantizer: (q - ZERO_DATA) * SCALE_W,
// sign-extended to 32 bits. Shared by the Ht/Ct/Xt paths.
module dequant_lane
  import dequant_ht_unpack_pkg::*;
#(
  parameter logic [7:0] ZERO_DATA = ZERO_DATA_DEF,
  parameter logic [9:0] SCALE_W   = SCALE_W_DEF
) (
  input  logic [7:0]  i_q,
  output logic [31:0] o_val
);

  logic signed [8:0]  w_diff;
  logic signed [10:0] w_scale;
  logic signed [19:0] w_prod;

  assign w_diff  = $signed({1'b0, i_q})
                 - $signed({1'b0, ZERO_DATA});
  assign w_scale = $signed({1'b0, SCALE_W});
  assign w_prod  = w_diff * w_scale;
  assign o_val   = {{12{w_prod[19]}}, w_prod};

endmodule

// File: rtl/dequant_ht_unpack.sv
// Unpacks 4x8-bit quantized words into a stream of 32-bit
// dequantized elements, one per cycle, valid/ready both sides.
module dequant_ht_unpack
  import dequant_ht_unpack_pkg::*;
#(
  parameter logic [9:0] SCALE_W   = SCALE_W_DEF,
  parameter logic [7:0] ZERO_DATA = ZERO_DATA_DEF,
  parameter int         VEC_LEN   = 64,
  parameter int         CNT_W     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done,
  output logic        busy
);

  localparam int NWORDS = (VEC_LEN + LANES - 1) / LANES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] NW       = CNT_W'(NWORDS);

  state_t r_state;
  state_t w_next;

  logic [31:0]      r_buf;
  logic             r_buf_valid;
  logic [1:0]       r_lane;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wcnt;
  logic [31:0]      r_out_data;
  logic             r_out_valid;
  logic             r_out_last;

  logic        w_adv;
  logic        w_words_rem;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_last_elem;
  logic        w_out_hs;
  logic        w_busy;
  logic        w_done;
  logic [7:0]  w_q;
  logic [31:0] w_val;

  assign w_adv       = r_buf_valid
                     & (~r_out_valid | out_ready);
  // words_remaining counts accepted words, so a
  // ragged tail never pulls in an extra word
  assign w_words_rem = (r_wcnt != NW);
  assign w_accept    = in_valid & w_in_ready;
  assign w_last_elem = (r_cnt == LAST_IDX);
  assign w_out_hs    = r_out_valid & out_ready;
  assign w_q         = lane_byte(r_buf, r_lane);

  dequant_lane #(
    .ZERO_DATA (ZERO_DATA),
    .SCALE_W   (SCALE_W)
  ) u_lane (
    .i_q   (w_q),
    .o_val (w_val)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_out_hs & r_out_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_in_ready = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_busy     = 1'b1;
        w_in_ready = w_words_rem
                   & (~r_buf_valid
                     | ((r_lane == LANE_LAST) & w_adv));
      end
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf       <= 32'd0;
      r_buf_valid <= 1'b0;
      r_lane      <= LANE_FIRST;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_out_data  <= 32'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_cnt       <= '0;
        r_wcnt      <= '0;
        r_lane      <= LANE_FIRST;
        r_buf_valid <= 1'b0;
      end
      if (w_accept) begin
        r_buf       <= in_word;
        r_buf_valid <= 1'b1;
        r_lane      <= LANE_FIRST;
        r_wcnt      <= r_wcnt + CNT_W'(1);
      end else if (w_adv) begin
        r_lane <= r_lane + 2'd1;
        // unused lanes of the final word are dropped
        if ((r_lane == LANE_LAST) || w_last_elem)
          r_buf_valid <= 1'b0;
      end
      if (w_adv) begin
        r_out_data  <= w_val;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_elem;
        r_cnt       <= r_cnt + CNT_W'(1);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = w_done;
  assign busy      = w_busy;

endmodule

// File: tb/tb_dequant_ht_unpack.sv
// Bench for dequant_ht_unpack: four instances with VEC_LEN
// 4/8/6/1 share the input bus; only the started one responds.
module tb_dequant_ht_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  start;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;
  logic [3:0]  irdy, ov, olast, odone, obusy;
  logic [31:0] odata [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dequant_ht_unpack #(
      .VEC_LEN (g == 0 ? 4 : g == 1 ? 8 : g == 2 ? 6 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start[g]),
      .in_valid  (in_valid),
      .in_ready  (irdy[g]),
      .in_word   (in_word),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (odata[g]),
      .out_last  (olast[g]),
      .done      (odone[g]),
      .busy      (obusy[g])
    );
  end

  function automatic int vlen(input int s);
    case (s)
      0: return 4;
      1: return 8;
      2: return 6;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0]      word;
    logic [3:0][31:0] e;
  } vec_t;

  vec_t tbl [3];

  // Exact-cycle single-word vector on the VEC_LEN=4 instance
  task automatic basic(input vec_t v);
    out_ready = 1'b1;
    start[0]  = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("bas_busy", 32'(obusy[0]), 32'd1);
    in_valid = 1'b1;
    in_word  = v.word;
    #1;
    chk("bas_irdy", 32'(irdy[0]), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bas_lat", 32'(ov[0]), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("bas_ov", 32'(ov[0]), 32'd1);
      chk("bas_data", odata[0], v.e[j]);
      chk("bas_last", 32'(olast[0]), 32'(j == 3));
    end
    tick();
    chk("bas_done", 32'(odone[0]), 32'd1);
    chk("bas_ov_drain", 32'(ov[0]), 32'd0);
    tick();
    chk("bas_done_end", 32'(odone[0]), 32'd0);
    chk("bas_busy_end", 32'(obusy[0]), 32'd0);
  endtask

  // mode: 0 full rate, 1 stall at element 2, 2 random,
  //       3 start pulsed mid-run, 4 reset after 3 outputs
  task automatic run_vec(input int s, input int mode);
    int          L, nw, wi, k, cyc, first, stall, b;
    bit          fin;
    logic [31:0] words [$];
    int          exp [$];
    L  = vlen(s);
    nw = (L + 3) / 4;
    for (int i = 0; i < nw + 2; i++)
      words.push_back($urandom);
    for (int i = 0; i < L; i++) begin
      b = int'((words[i / 4] >> (8 * (i % 4))) & 32'hFF);
      exp.push_back((b - 128) * 128);
    end
    wi = 0; k = 0; cyc = 0; first = -1; stall = 0;
    fin = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start[s]  = 1'b1;
    tick();
    start[s] = 1'b0;
    chk("run_busy", 32'(obusy[s]), 32'd1);
    while (!fin && cyc < 500) begin
      in_valid  = (mode == 2) ? 1'($urandom % 2) : 1'b1;
      in_word   = words[(wi < nw + 2) ? wi : 0];
      if (mode == 2)
        out_ready = ($urandom % 4) != 0;
      else
        out_ready = !(mode == 1 && k == 2 && stall < 5);
      start[s] = (mode == 3 && k == 2);
      #1;
      if (in_valid && irdy[s]) wi++;
      if (ov[s] && !out_ready && mode == 1) begin
        chk("stall_data", odata[s], 32'(exp[k]));
        chk("stall_last", 32'(olast[s]), 32'd0);
        chk("stall_irdy", 32'(irdy[s]), 32'd0);
        stall++;
      end
      if (ov[s] && out_ready) begin
        chk("out_data", odata[s], 32'(exp[k]));
        chk("out_last", 32'(olast[s]), 32'(k == L - 1));
        if (first < 0) first = cyc;
        if (mode == 0 || mode == 3) begin
          chk("no_bubble", 32'(cyc - first), 32'(k));
          if (k % 4 == 2 && k / 4 < nw - 1)
            chk("lane3_irdy", 32'(irdy[s]), 32'd1);
        end
        k++;
        if (k == L) fin = 1'b1;
      end
      if (mode == 4 && k == 3) begin
        reset = 1'b1;
        tick();
        chk("rst_ov", 32'(ov[s]), 32'd0);
        chk("rst_irdy", 32'(irdy[s]), 32'd0);
        chk("rst_done", 32'(odone[s]), 32'd0);
        chk("rst_busy", 32'(obusy[s]), 32'd0);
        reset    = 1'b0;
        start[s] = 1'b0;
        in_valid = 1'b0;
        return;
      end
      tick();
      cyc++;
    end
    start[s] = 1'b0;
    chk("elem_count", 32'(k), 32'(L));
    chk("end_done", 32'(odone[s]), 32'd1);
    chk("end_ov", 32'(ov[s]), 32'd0);
    chk("end_busy", 32'(obusy[s]), 32'd0);
    in_valid = 1'b1;
    #1;
    chk("end_irdy", 32'(irdy[s]), 32'd0);
    tick();
    chk("done_pulse", 32'(odone[s]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_irdy", 32'(irdy[s]), 32'd0);
      chk("idle_ov", 32'(ov[s]), 32'd0);
    end
    chk("words_acc", 32'(wi), 32'(nw));
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0].word = 32'h0081FF80;
    tbl[0].e    = {32'hFFFFC000, 32'd128,
                   32'd16256, 32'd0};
    tbl[1].word = 32'h807F0102;
    tbl[1].e    = {32'd0, 32'(-128),
                   32'(-16256), 32'(-16128)};
    tbl[2].word = 32'hFE40C0FF;
    tbl[2].e    = {32'd16128, 32'(-8192),
                   32'd8192, 32'd16256};

    reset     = 1'b1;
    start     = 4'd0;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ov_all", 32'(ov), 32'd0);
    chk("rst_irdy_all", 32'(irdy), 32'd0);
    chk("rst_last_all", 32'(olast), 32'd0);
    chk("rst_done_all", 32'(odone), 32'd0);
    chk("rst_busy_all", 32'(obusy), 32'd0);
    for (int g = 0; g < 4; g++)
      chk("rst_data", odata[g], 32'd0);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    #1;
    chk("idle_irdy0", 32'(irdy), 32'd0);
    tick();
    chk("idle_ov0", 32'(ov), 32'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 3; i++) basic(tbl[i]);

    run_vec(1, 0);
    run_vec(1, 1);
    run_vec(2, 0);
    run_vec(1, 3);
    run_vec(1, 4);
    run_vec(1, 0);
    run_vec(3, 0);
    run_vec(0, 0);
    for (int r = 0; r < 8; r++) run_vec(r % 4, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
